// File: rtl/fc_engine_pkg.sv
// Shared types, default widths and the requantisation arithmetic for fc_engine.
package fc_engine_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_MAX_IN = 1024;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_IN   = 3'd1,
        LOAD_BIAS = 3'd2,
        MAC       = 3'd3,
        WRITE     = 3'd4,
        FINISH    = 3'd5
    } state_t;

    // Round-half-up arithmetic shift, optional clamp of negatives, then signed saturation.
    // Evaluated in 64 bits so the rounding add cannot overflow the accumulator width.
    function automatic logic [63:0] requant(input logic signed [63:0] acc,
                                            input logic [4:0]         shift,
                                            input int                 data_w,
                                            input logic               relu);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = acc;
        if (shift != 5'd0)
            v = v + (64'sd1 <<< (shift - 5'd1));
        v  = v >>> shift;
        if (relu && (v < 0))
            v = 64'sd0;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational requantiser: accumulator -> DATA_W output element.
// Define FC_ENGINE_RELU_EN to clamp negative shifted values to zero before saturation.
module fc_requant
    import fc_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [4:0]        shift,
    output logic [DATA_W-1:0] q
);

`ifdef FC_ENGINE_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic signed [63:0] acc_ext;

    assign acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign q       = DATA_W'(requant(acc_ext, shift, DATA_W, RELU));

endmodule

// File: rtl/fc_engine.sv
// Fully-connected layer engine: loads an input vector, then per neuron loads bias,
// accumulates weight products and writes a requantised result (ReLU via FC_ENGINE_RELU_EN).
module fc_engine
    import fc_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int MAX_IN = DEF_MAX_IN,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] input_ptr,
    input  logic [ADDR_W-1:0] weights_ptr,
    input  logic [ADDR_W-1:0] bias_ptr,
    input  logic [ADDR_W-1:0] output_ptr,
    input  logic [15:0]       in_size,
    input  logic [15:0]       out_size,
    input  logic [4:0]        out_shift,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_rvalid,
    input  logic [ACC_W-1:0]  rd_rdata,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_gnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BUF_AW = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  in_ptr_reg, w_ptr_reg, b_ptr_reg, out_ptr_reg, w_idx_reg;
    logic [15:0]        in_size_reg, out_size_reg, k_reg, o_reg;
    logic [4:0]         shift_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               pending_reg, err_reg;
    logic [DATA_W-1:0]  buf_mem [MAX_IN];
    logic [DATA_W-1:0]  buf_q_reg;

    logic               job_ok, accept, rd_done, k_last, o_more;
    logic signed [ACC_W-1:0] a_ext, w_ext;
    logic [ACC_W-1:0]   prod;

    assign job_ok  = (in_size != 16'd0) && (out_size != 16'd0) && (int'(in_size) <= MAX_IN);
    assign accept  = (state_reg == IDLE) && start && job_ok;
    assign rd_done = pending_reg && rd_rvalid;
    assign k_last  = (k_reg == in_size_reg - 16'd1);
    assign o_more  = (17'(o_reg) + 17'd1) < 17'(out_size_reg);

    assign a_ext = {{(ACC_W-DATA_W){buf_q_reg[DATA_W-1]}}, buf_q_reg};
    assign w_ext = {{(ACC_W-DATA_W){rd_rdata[DATA_W-1]}}, rd_rdata[DATA_W-1:0]};
    assign prod  = a_ext * w_ext;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:      if (accept)             state_next = LOAD_IN;
            LOAD_IN:   if (rd_done && k_last)  state_next = LOAD_BIAS;
            LOAD_BIAS: if (rd_done)            state_next = MAC;
            MAC:       if (rd_done && k_last)  state_next = WRITE;
            WRITE:     if (wr_gnt)             state_next = o_more ? LOAD_BIAS : FINISH;
            FINISH:                            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Read address depends only on registered counters, so it is stable until granted.
    always_comb begin
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_reg)
            IDLE:      busy = 1'b0;
            LOAD_IN:   begin rd_req = !pending_reg; rd_addr = in_ptr_reg + ADDR_W'(k_reg); end
            LOAD_BIAS: begin rd_req = !pending_reg; rd_addr = b_ptr_reg + ADDR_W'({o_reg, 2'b00}); end
            MAC:       begin rd_req = !pending_reg; rd_addr = w_ptr_reg + w_idx_reg; end
            WRITE:     begin wr_req = 1'b1; wr_addr = out_ptr_reg + ADDR_W'(o_reg); end
            FINISH:    done = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    assign err = err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ptr_reg   <= '0;
            w_ptr_reg    <= '0;
            b_ptr_reg    <= '0;
            out_ptr_reg  <= '0;
            in_size_reg  <= '0;
            out_size_reg <= '0;
            shift_reg    <= '0;
            k_reg        <= '0;
            o_reg        <= '0;
            w_idx_reg    <= '0;
            acc_reg      <= '0;
            pending_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= (state_reg == IDLE) && start && !job_ok;
            if (accept) begin
                in_ptr_reg   <= input_ptr;
                w_ptr_reg    <= weights_ptr;
                b_ptr_reg    <= bias_ptr;
                out_ptr_reg  <= output_ptr;
                in_size_reg  <= in_size;
                out_size_reg <= out_size;
                shift_reg    <= out_shift;
                k_reg        <= '0;
                o_reg        <= '0;
                w_idx_reg    <= '0;
                acc_reg      <= '0;
            end
            if (rd_req && rd_gnt)
                pending_reg <= 1'b1;
            else if (rd_done)
                pending_reg <= 1'b0;
            if (rd_done) begin
                case (state_reg)
                    LOAD_IN:   k_reg <= k_last ? 16'd0 : k_reg + 16'd1;
                    LOAD_BIAS: begin acc_reg <= rd_rdata; k_reg <= '0; end
                    MAC: begin
                        acc_reg   <= acc_reg + prod;
                        w_idx_reg <= w_idx_reg + ADDR_W'(1);
                        k_reg     <= k_last ? 16'd0 : k_reg + 16'd1;
                    end
                    default: ;
                endcase
            end
            if ((state_reg == WRITE) && wr_gnt)
                o_reg <= o_reg + 16'd1;
        end
    end

    // Input buffer; the registered read lands well before the matching weight returns.
    always_ff @(posedge clk) begin
        if (rd_done && (state_reg == LOAD_IN))
            buf_mem[k_reg[BUF_AW-1:0]] <= rd_rdata[DATA_W-1:0];
        buf_q_reg <= buf_mem[k_reg[BUF_AW-1:0]];
    end

    fc_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_requant (
        .acc   (acc_reg),
        .shift (shift_reg),
        .q     (wr_data)
    );

endmodule

// File: doc/fc_engine.md
FC_ENGINE -- requirements
Module: fc_engine

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, signed element width; ACC_W, default 32, accumulator/bias width; MAX_IN, default 1024, input buffer depth; ADDR_W, default 32, byte-address width.
REQ-002 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 input_ptr, weights_ptr, bias_ptr, output_ptr  input  ADDR_W each  byte base addresses; latched on accept.
REQ-006 in_size, out_size  input  16 each  vector length and neuron count; latched on accept.
REQ-007 out_shift  input  5  requantisation right shift; latched on accept.
REQ-008 rd_req / rd_addr / rd_gnt  output / output ADDR_W / input  read request; transfer occurs when rd_req&&rd_gnt.
REQ-009 rd_rvalid / rd_rdata  input / input ACC_W  read response, in order.
REQ-010 wr_req / wr_addr / wr_data / wr_gnt  output / output ADDR_W / output DATA_W / input  write; transfer occurs when wr_req&&wr_gnt.
REQ-011 busy / done / err  output 1 each  busy while not IDLE; done 1-cycle pulse; err 1-cycle pulse on rejected job.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD_IN, LOAD_BIAS, MAC, WRITE and FINISH.
REQ-013 In IDLE with start=1: if in_size==0, out_size==0 or in_size>MAX_IN, the block SHALL pulse err the next cycle and stay IDLE; otherwise it SHALL latch all job inputs and enter LOAD_IN.
REQ-014 At most one read SHALL be outstanding; rd_req SHALL hold with a stable rd_addr until granted, and the next request SHALL issue no earlier than the cycle after rd_rvalid.
REQ-015 LOAD_IN SHALL read elements k=0..in_size-1 at input_ptr+k and store sign-extended rd_rdata[DATA_W-1:0] in the local buffer, then go to LOAD_BIAS with o=0.
REQ-016 LOAD_BIAS SHALL read the full ACC_W word at bias_ptr+4*o into the accumulator, then go to MAC.
REQ-017 MAC SHALL read the weight at weights_ptr+o*in_size+k for k=0..in_size-1 and add buffer[k]*weight to the accumulator; the accumulator SHALL wrap modulo 2^ACC_W.
REQ-018 WRITE SHALL apply an arithmetic right shift by out_shift with round-half-up (add 1<<(out_shift-1) when out_shift>0), saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and hold wr_req until granted at output_ptr+o.
REQ-019 After the write grant, the FSM SHALL return to LOAD_BIAS with o+1 if o+1<out_size, and otherwise enter FINISH.
REQ-020 FINISH SHALL pulse done for one cycle and return to IDLE; start in FINISH SHALL be ignored.
REQ-021 start outside IDLE SHALL be ignored, and latched job inputs SHALL not change mid-job.

Reset
REQ-022 While rst_n=0: the state SHALL be IDLE; busy, done, err, rd_req and wr_req SHALL be 0; the counters and accumulator SHALL be 0.
REQ-023 Reset mid-job SHALL abandon the job and drop rd_req/wr_req the next cycle; responses arriving after reset SHALL be ignored; buffer contents need not be cleared.

Configuration
REQ-024 With FC_ENGINE_RELU_EN defined, negative values after the shift SHALL be clamped to 0 before saturation; without it, the output SHALL be signed saturation only.

Structure
REQ-025 The state encoding, default widths and the saturate/round function SHALL reside in package fc_engine_pkg.
REQ-026 The requantise step (shift, round, optional ReLU, saturate) SHALL be a combinational sub-module fc_requant, instanced once.

Verification
REQ-027 With in_size=4, out_size=2, inputs {1,2,3,4}, weights {1,1,1,1, -1,0,0,2}, biases {10,-5}, shift 0 and grants always high, the bench SHALL see writes 20 then 2 and one done pulse.
REQ-028 A job with in_size=0 or in_size=MAX_IN+1 SHALL produce an err pulse, no memory traffic and no done.
REQ-029 An accumulator of 1000 with shift 2 SHALL write 127; -1000 SHALL write -128 without RELU_EN and 0 with RELU_EN; 6 with shift 2 SHALL write 2 (rounded).
REQ-030 With rd_gnt/wr_gnt randomly low 50% of cycles and random rd_rvalid delay 0-5 cycles, results SHALL be identical to REQ-027 and rd_addr SHALL stay stable while ungranted.
REQ-031 Asserting rst_n=0 during MAC of neuron 1 SHALL give busy=0 and rd_req=0 the next cycle; a fresh start SHALL then complete correctly.
